fan_angle_sequencer: RTL
========================

# fan_angle_sequencer

Angle-tick generator and pattern scheduler for the LED fan POV display. It measures the revolution period from the once-per-revolution hall-sensor index and spreads exactly 360 angle steps across it. It drives the downcounting angle (360..1) and one-cycle `fanclk` ticks consumed by the pattern renderers. It also chooses which pattern is shown and switches patterns only at revolution boundaries, using a request/acknowledge handshake with the renderer.

## Interface

- `PERIOD_W`, 24: width of the revolution-period counter; all-ones is the stall timeout.
- `MIN_PERIOD`, 720: shortest accepted revolution in clk cycles; shorter index intervals are glitches.
- `REV_PER_PATTERN`, 8: revolutions shown per pattern before a change is requested.
- `PAT_W`, 2: pattern index width; patterns 0..2^PAT_W-1, wrapping.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `index`  in  1  hall-sensor level, already synchronous to `clk`; a rising edge marks angle 360.
- `pat_ack`  in  1  renderer has preloaded `pat_next`; sampled only while `pat_req`=1.
- `fanclk`  out  1  one-cycle pulse per angle decrement.
- `deg`  out  9  current angle, 360 down to 1.
- `pattern`  out  PAT_W  active pattern index.
- `pat_next`  out  PAT_W  pattern to be shown next; equals `pattern`+1 mod 2^PAT_W.
- `pat_req`  out  1  pattern-change request; held until `pat_ack`.
- `locked`  out  1  a valid period is measured and ticks are running.

## Operation

- Edge detect: `index_q` is the registered `index`. `edge = index & ~index_q`.
- Period counter `pcnt` increments every cycle and saturates at all-ones. On an accepted edge, `pcnt` is copied into `period`, then `pcnt` restarts at 1.
- An edge is accepted only if `pcnt` >= `MIN_PERIOD`. A rejected edge is ignored entirely: `pcnt` keeps counting and no state changes.
- States:
  - IDLE (reset state): `locked`=0, no ticks. Goes to MEASURE on an edge; `pcnt` restarts and the edge is not checked against `MIN_PERIOD`.
  - MEASURE: goes to RUN on the next accepted edge. The first `period` is latched, `deg`=360, `locked`=1.
  - RUN: ticks run. Each accepted edge latches `period`, sets `deg`=360, clears the accumulator and advances the revolution count.
- Stall: in MEASURE or RUN, `pcnt` reaching all-ones moves the block to IDLE. `locked`=0, `deg`=360, accumulator cleared. `pattern`, `pat_req` and the revolution count are held.
- Tick generation (RUN only) uses a Bresenham accumulator `acc`, PERIOD_W+1 bits:
  - Every cycle `acc` += 360.
  - If the sum >= `period`, subtract `period` and raise a tick.
  - `MIN_PERIOD` >= 360 guarantees at most one tick per cycle.
- A tick with `deg` > 1 decrements `deg` and pulses `fanclk`. A tick with `deg` = 1 is swallowed; `deg` holds at 1 until the edge.
- An edge and a tick in the same cycle: the edge wins. `deg`=360, no `fanclk`.
- Revolution count `rcnt` (RUN, accepted edges only):
  - When `rcnt` reaches `REV_PER_PATTERN`-1 on an edge, `rcnt` goes to 0 and `pat_req` is set, if not already pending.
  - While a request is pending, `rcnt` keeps counting but no second request is issued.
- Handshake:
  - `pat_ack` while `pat_req`=1 sets an internal `armed` flag and clears `pat_req` on the next cycle.
  - On the next accepted edge with `armed`=1, `pattern` becomes `pat_next` and `armed` clears.
  - `pat_ack` in the same cycle as an accepted edge switches `pattern` at that edge.
  - `pat_ack` while `pat_req`=0 is ignored.

## Timing

- Reset values: `fanclk`=0, `deg`=360, `pattern`=0, `pat_next`=1, `pat_req`=0, `locked`=0. Internally IDLE, `acc`=0, `rcnt`=0, `armed`=0.
- An `index` rising edge at cycle t is detected at t+1. Its registered effects (`deg`, `period`, `pattern`, `locked`) are visible at t+2.
- `fanclk` and the matching `deg` update appear together, registered one cycle after the accumulator crosses `period`.
- `pat_req` rises in the same cycle that the triggering edge's effects appear. It falls one cycle after `pat_ack` is sampled high.
- Reset asserted mid-operation: all outputs take reset values on the next edge. A pending request is dropped.

## Test plan

- Reset: hold `rst`=0 for 3 cycles with `index` toggling -> `deg`=360, `fanclk`=0, `locked`=0, `pattern`=0, `pat_req`=0.
- Lock and tick: index edges every 3600 cycles -> `locked`=1 after the second edge; `fanclk` every 10 cycles, 359 pulses per revolution; `deg` goes 360 -> 1 and returns to 360 at each edge.
- Uneven period: period 1000 -> 359 pulses per revolution, spacing 2 or 3 cycles, `deg`=1 just before each edge.
- Glitch and stall:
  - An extra edge 100 cycles after a valid edge -> ignored, tick stream undisturbed.
  - Stop `index` -> `locked`=0 and ticks stop when `pcnt` saturates.
- Pattern change: `REV_PER_PATTERN`=8 -> `pat_req` after the 8th RUN revolution. `pat_ack` mid-revolution -> `pattern` goes 0 -> 1 exactly at the next edge. Four changes wrap `pattern` back to 0.
- Reset mid-request: `rst`=0 while `pat_req`=1 -> `pat_req`=0 and `pattern`=0 after the next clock; relocking requires two edges again.

Source files
------------

// File: rtl/fan_angle_sequencer_if.sv
// Signal bundle between the fan angle sequencer and the pattern renderers.
// The sequencer side uses the master modport; the renderer side uses slave.
interface fan_angle_sequencer_if #(
    parameter int PAT_W = 2
);
    logic             index;
    logic             pat_ack;
    logic             fanclk;
    logic [8:0]       deg;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] pat_next;
    logic             pat_req;
    logic             locked;

    modport master (
        input  index, pat_ack,
        output fanclk, deg, pattern, pat_next, pat_req, locked
    );

    modport slave (
        output index, pat_ack,
        input  fanclk, deg, pattern, pat_next, pat_req, locked
    );
endinterface

// File: rtl/fan_angle_sequencer.sv
// Revolution-locked angle tick generator and pattern scheduler for the POV fan.
// Spreads 360 angle steps over the measured hall-index period and sequences patterns.
module fan_angle_sequencer #(
    parameter int PERIOD_W        = 24,
    parameter int MIN_PERIOD      = 720,
    parameter int REV_PER_PATTERN = 8,
    parameter int PAT_W           = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fan_angle_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_e;

    localparam int                  RCNT_W    = (REV_PER_PATTERN > 1) ? $clog2(REV_PER_PATTERN) : 1;
    localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;
    localparam logic [PERIOD_W-1:0] PCNT_ONE  = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   DEG_STEP  = (PERIOD_W+1)'(360);
    localparam logic [8:0]          DEG_TOP   = 9'd360;
    localparam logic [RCNT_W-1:0]   RCNT_LAST = RCNT_W'(REV_PER_PATTERN - 1);

    state_e              state_q, state_d;
    logic                index_q;
    logic                edge_q;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W:0]   acc_q, acc_d, acc_sum;
    logic [8:0]          deg_q, deg_d;
    logic                fanclk_q, fanclk_d;
    logic [PAT_W-1:0]    pattern_q, pattern_d;
    logic                pat_req_q, pat_req_d;
    logic                armed_q, armed_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;

    logic edge_ok;
    logic run_edge;
    logic tick;
    logic take;
    logic pat_switch;

    // Next-state, tick and handshake logic; an accepted edge outranks stall and ticks.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = (pcnt_q == PCNT_MAX) ? PCNT_MAX : pcnt_q + 1'b1;
        period_d = period_q;
        acc_d    = acc_q;
        deg_d    = deg_q;
        fanclk_d = 1'b0;

        acc_sum    = acc_q + DEG_STEP;
        edge_ok    = edge_q && (state_q != IDLE) && (pcnt_q >= MIN_P);
        run_edge   = edge_ok && (state_q == RUN);
        tick       = (state_q == RUN) && (acc_sum >= {1'b0, period_q});
        take       = bus.pat_ack && pat_req_q;
        pat_switch = edge_ok && (armed_q || take);

        if (state_q == IDLE) begin
            if (edge_q) begin
                state_d = MEASURE;
                pcnt_d  = PCNT_ONE;
            end
        end else if (edge_ok) begin
            state_d  = RUN;
            pcnt_d   = PCNT_ONE;
            period_d = pcnt_q;
            acc_d    = '0;
            deg_d    = DEG_TOP;
        end else if (pcnt_q == PCNT_MAX) begin
            state_d = IDLE;
            acc_d   = '0;
            deg_d   = DEG_TOP;
        end else if (state_q == RUN) begin
            acc_d = tick ? (acc_sum - {1'b0, period_q}) : acc_sum;
            if (tick && (deg_q > 9'd1)) begin
                deg_d    = deg_q - 1'b1;
                fanclk_d = 1'b1;
            end
        end

        pattern_d = pat_switch ? pattern_q + 1'b1 : pattern_q;
        armed_d   = pat_switch ? 1'b0 : (take ? 1'b1 : armed_q);
        pat_req_d = take ? 1'b0 : (pat_req_q || (run_edge && (rcnt_q == RCNT_LAST)));
        rcnt_d    = rcnt_q;
        if (run_edge) begin
            rcnt_d = (rcnt_q == RCNT_LAST) ? '0 : rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            index_q   <= 1'b0;
            edge_q    <= 1'b0;
            pcnt_q    <= '0;
            acc_q     <= '0;
            deg_q     <= DEG_TOP;
            fanclk_q  <= 1'b0;
            pattern_q <= '0;
            pat_req_q <= 1'b0;
            armed_q   <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= bus.index;
            edge_q    <= bus.index & ~index_q;
            pcnt_q    <= pcnt_d;
            acc_q     <= acc_d;
            deg_q     <= deg_d;
            fanclk_q  <= fanclk_d;
            pattern_q <= pattern_d;
            pat_req_q <= pat_req_d;
            armed_q   <= armed_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // The period is only read in RUN, which is always entered by latching it.
    always_ff @(posedge clk) begin
        period_q <= period_d;
    end

    assign bus.fanclk   = fanclk_q;
    assign bus.deg      = deg_q;
    assign bus.pattern  = pattern_q;
    assign bus.pat_next = pattern_q + 1'b1;
    assign bus.pat_req  = pat_req_q;
    assign bus.locked   = (state_q == RUN);
endmodule
